// File: rtl/nibble_frame_assembler.sv
// nibble_frame_assembler: packs three slot-timed nibbles into a 12-bit word behind a 2-entry FIFO.
// Optional FRAME_CHKSUM_EN adds out_chk, the XOR of the three nibbles, carried alongside each word.
module nibble_frame_assembler #(
  parameter int FIRST_SLOT  = 4,
  parameter int SLOT_STRIDE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  nib_in,
  output logic [11:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_abort,
  output logic        overflow
`ifdef FRAME_CHKSUM_EN
  ,
  output logic [3:0]  out_chk
`endif
);
  localparam logic [3:0] S0 = 4'(FIRST_SLOT);
  localparam logic [3:0] S1 = 4'(FIRST_SLOT + SLOT_STRIDE);
  localparam logic [3:0] S2 = 4'(FIRST_SLOT + 2 * SLOT_STRIDE);
`ifdef FRAME_CHKSUM_EN
  localparam int EW = 16;
`else
  localparam int EW = 12;
`endif
  typedef enum logic [1:0] {IDLE, GOT0, GOT1} state_t;
  state_t        state_q, state_d;
  logic [3:0]    slot_q;
  logic [7:0]    part_q, part_d;
  logic [EW-1:0] e0_q, e0_d, e1_q, e1_d, new_entry;
  logic [1:0]    cnt_q, cnt_d;
  logic          abort_q, abort_d, ovf_q, ovf_d, push, pop;
`ifdef FRAME_CHKSUM_EN
  assign new_entry = {part_q, nib_in, part_q[7:4] ^ part_q[3:0] ^ nib_in};
  assign out_chk   = e0_q[3:0];
`else
  assign new_entry = {part_q, nib_in};
`endif
  assign out_word    = e0_q[EW-1 -: 12];
  assign out_valid   = cnt_q != 2'd0;
  assign frame_abort = abort_q;
  assign overflow    = ovf_q;
  assign pop         = out_valid && out_ready;
  always_comb begin
    state_d = state_q;
    part_d  = part_q;
    abort_d = 1'b0;
    push    = 1'b0;
    if (state_q == IDLE) begin
      if (enable && slot_q == S0) begin
        state_d     = GOT0;
        part_d[7:4] = nib_in;
      end
    end else if (!enable) begin
      state_d = IDLE;
      abort_d = 1'b1;
    end else if (state_q == GOT0 && slot_q == S1) begin
      state_d     = GOT1;
      part_d[3:0] = nib_in;
    end else if (state_q == GOT1 && slot_q == S2) begin
      state_d = IDLE;
      push    = 1'b1;
    end
  end
  // Pop is applied first so a push into a full buffer that is also popping still lands.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (pop) begin
      e0_d  = e1_q;
      cnt_d = cnt_q - 2'd1;
    end
    if (push && cnt_d == 2'd2) ovf_d = 1'b1;
    else if (push) begin
      if (cnt_d == 2'd0) e0_d = new_entry;
      else e1_d = new_entry;
      cnt_d = cnt_d + 2'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q  <= 4'd0;
      state_q <= IDLE;
      part_q  <= 8'd0;
      e0_q    <= '0;
      e1_q    <= '0;
      cnt_q   <= 2'd0;
      abort_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      slot_q  <= slot_q + 4'd1;
      state_q <= state_d;
      part_q  <= part_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_nibble_frame_assembler.sv
// tb_nibble_frame_assembler: table-driven frame vectors plus directed overflow, full-buffer and reset sequences.
module tb_nibble_frame_assembler;
  logic        clk = 1'b0, rst, enable, out_ready;
  logic [3:0]  nib_in;
  logic [11:0] out_word;
  logic        out_valid, frame_abort, overflow;
  logic [3:0]  slot;
  int          n_cmp = 0, n_fail = 0;
`ifdef FRAME_CHKSUM_EN
  logic [3:0]  out_chk;
`endif

  nibble_frame_assembler dut (
    .clk(clk), .rst(rst), .enable(enable), .nib_in(nib_in),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .frame_abort(frame_abort), .overflow(overflow)
`ifdef FRAME_CHKSUM_EN
    , .out_chk(out_chk)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a, b, c;
    bit          abort;
    bit          exp_valid;
    logic [11:0] exp_word;
    logic [3:0]  exp_chk;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // slot mirrors the counter value seen by the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    slot = slot + 4'd1;
  endtask

  task automatic run_to(input logic [3:0] s);
    while (slot != s) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    slot = 4'd0;
  endtask

  task automatic capture(input logic [3:0] a, input logic [3:0] b);
    enable = 1'b1;
    run_to(4'd4); nib_in = a; tick();
    run_to(4'd6); nib_in = b; tick();
    tick();
  endtask

  task automatic do_frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    capture(a, b);
    nib_in = c;
    tick();
  endtask

  initial begin
    vt[0] = '{4'hA, 4'h5, 4'hC, 1'b0, 1'b1, 12'hA5C, 4'h3};
    vt[1] = '{4'h1, 4'h2, 4'h3, 1'b1, 1'b0, 12'h000, 4'h0};
    vt[2] = '{4'h7, 4'hE, 4'h9, 1'b0, 1'b1, 12'h7E9, 4'h0};
    vt[3] = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 12'h000, 4'h0};
    vt[4] = '{4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 12'hFFF, 4'hF};
    rst = 1'b1; enable = 1'b0; out_ready = 1'b0; nib_in = 4'h0; slot = 4'd0;
    #2;
    chk("rst_valid", 16'(out_valid), 16'h0);
    chk("rst_word", 16'(out_word), 16'h0);
    chk("rst_abort", 16'(frame_abort), 16'h0);
    chk("rst_ovf", 16'(overflow), 16'h0);
`ifdef FRAME_CHKSUM_EN
    chk("rst_chk", 16'(out_chk), 16'h0);
`endif
    do_reset();

    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      enable = 1'b1;
      run_to(4'd4); nib_in = vt[i].a; tick();
      run_to(4'd6); nib_in = vt[i].b; tick();
      enable = !vt[i].abort;
      tick();
      chk($sformatf("v%0d_abort_pulse", i), 16'(frame_abort), 16'(vt[i].abort));
      enable = 1'b1; nib_in = vt[i].c;
      tick();
      chk($sformatf("v%0d_valid", i), 16'(out_valid), 16'(vt[i].exp_valid));
      chk($sformatf("v%0d_abort_end", i), 16'(frame_abort), 16'h0);
      if (vt[i].exp_valid) begin
        chk($sformatf("v%0d_word", i), 16'(out_word), 16'(vt[i].exp_word));
`ifdef FRAME_CHKSUM_EN
        chk($sformatf("v%0d_chk", i), 16'(out_chk), 16'(vt[i].exp_chk));
`endif
      end
      tick();
      chk($sformatf("v%0d_valid_drop", i), 16'(out_valid), 16'h0);
    end

    // enable low at the S0 edge: no frame, no abort
    run_to(4'd4); enable = 1'b0; nib_in = 4'h9; tick();
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("nostart_abort%0d", k), 16'(frame_abort), 16'h0);
    end
    chk("nostart_valid", 16'(out_valid), 16'h0);

    // back-pressure: third frame overflows the 2-entry buffer
    out_ready = 1'b0;
    do_frame(4'h1, 4'h2, 4'h3);
    chk("ovf_f1_valid", 16'(out_valid), 16'h1);
    chk("ovf_f1_word", 16'(out_word), 16'h123);
    chk("ovf_f1_ovf", 16'(overflow), 16'h0);
    do_frame(4'h4, 4'h5, 4'h6);
    chk("ovf_f2_word", 16'(out_word), 16'h123);
    chk("ovf_f2_ovf", 16'(overflow), 16'h0);
    do_frame(4'h7, 4'h8, 4'h9);
    chk("ovf_f3_ovf", 16'(overflow), 16'h1);
    chk("ovf_f3_word", 16'(out_word), 16'h123);
    out_ready = 1'b1;
    tick();
    chk("ovf_drain_word", 16'(out_word), 16'h456);
    chk("ovf_drain_valid", 16'(out_valid), 16'h1);
    tick();
    chk("ovf_empty_valid", 16'(out_valid), 16'h0);
    chk("ovf_sticky", 16'(overflow), 16'h1);

    // full buffer with a pop on the S2 edge accepts the new word
    do_reset();
    out_ready = 1'b0;
    do_frame(4'h1, 4'h2, 4'h3);
    do_frame(4'h4, 4'h5, 4'h6);
    capture(4'h7, 4'h8);
    nib_in = 4'h9; out_ready = 1'b1;
    tick();
    chk("full_pp_word", 16'(out_word), 16'h456);
    chk("full_pp_valid", 16'(out_valid), 16'h1);
    chk("full_pp_ovf", 16'(overflow), 16'h0);
    tick();
    chk("full_pp_next", 16'(out_word), 16'h789);
    tick();
    chk("full_pp_empty", 16'(out_valid), 16'h0);
    chk("full_pp_ovf2", 16'(overflow), 16'h0);

    // reset in GOT1 with one buffered word
    do_reset();
    out_ready = 1'b0;
    do_frame(4'h1, 4'h2, 4'h3);
    chk("mid_buffered", 16'(out_valid), 16'h1);
    capture(4'h4, 4'h5);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 16'(out_valid), 16'h0);
    chk("mid_rst_word", 16'(out_word), 16'h0);
    chk("mid_rst_abort", 16'(frame_abort), 16'h0);
    @(posedge clk);
    #1;
    chk("mid_rst_abort2", 16'(frame_abort), 16'h0);
    chk("mid_rst_ovf", 16'(overflow), 16'h0);
    rst = 1'b0; slot = 4'd0;
    out_ready = 1'b1;
    capture(4'hA, 4'h5);
    chk("post_rst_abort", 16'(frame_abort), 16'h0);
    chk("post_rst_empty", 16'(out_valid), 16'h0);
    nib_in = 4'hC;
    tick();
    chk("post_rst_valid", 16'(out_valid), 16'h1);
    chk("post_rst_word", 16'(out_word), 16'hA5C);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
